// File: rtl/key_filter.sv
// key_filter: per-key debounce, one-shot and optional auto-repeat for
// active-low push buttons. Each key is synchronised, debounced by a small
// four-state FSM and turned into a one-cycle active-high press pulse plus
// a stable active-high level. Keys are filtered fully independently.
module key_filter #(
    parameter int              KEY_W       = 4,
    parameter int              DB_CYCLES   = 1_000_000,
    parameter int              HOLD_CYCLES = 50_000_000,
    parameter int              RPT_CYCLES  = 10_000_000,
    parameter logic [KEY_W-1:0] RPT_MASK   = KEY_W'(4'b0011)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_pulse,
    output logic [KEY_W-1:0] key_level
);

    // One counter width serves debounce, hold and repeat timing.
    localparam int MAX_AB  = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_AB > RPT_CYCLES) ? MAX_AB : RPT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Terminal counts are "last value before the event": the transition edge
    // itself is the DB_CYCLES-th (or HOLD/RPT-th) counted sample.
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    logic [KEY_W-1:0] sync1_q;
    logic [KEY_W-1:0] sync_q;

    state_t           state_q [KEY_W];
    state_t           state_d [KEY_W];
    logic [CNT_W-1:0] cnt_q   [KEY_W];
    logic [CNT_W-1:0] cnt_d   [KEY_W];
    logic [KEY_W-1:0] rpt_q, rpt_d;      // 1 = hold delay done, now repeating
    logic [KEY_W-1:0] pulse_q, pulse_d;

    // Saturating increment: counters must never wrap back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_ONE;
    endfunction

    // Two-flop synchroniser; reset to 1 so every key starts "released".
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would collapse the two stages.
        if (!rstn) begin
            sync1_q <= '1;
            sync_q  <= '1;
        end else begin
            sync1_q <= key_in;
            sync_q  <= sync1_q;
        end
    end

    // State register: per-key FSM state, counter, repeat flag, pulse flop.
    always_ff @(posedge clk) begin
        // NOTE: these per-key arrays are plain flops, not RAM, so resetting
        // every entry is cheap and gives a fully defined start state.
        if (!rstn) begin
            for (int k = 0; k < KEY_W; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= '0;
            end
            rpt_q   <= '0;
            pulse_q <= '0;
        end else begin
            for (int k = 0; k < KEY_W; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            rpt_q   <= rpt_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state logic: debounce, press detection and hold/repeat timing.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        for (int k = 0; k < KEY_W; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
        end
        rpt_d   = rpt_q;
        pulse_d = '0;

        for (int k = 0; k < KEY_W; k++) begin
            unique case (state_q[k])
                IDLE: begin
                    if (!sync_q[k]) begin
                        state_d[k] = PRESS_DB;
                        cnt_d[k]   = CNT_ONE;
                    end else begin
                        cnt_d[k] = '0;
                    end
                end
                PRESS_DB: begin
                    if (sync_q[k]) begin
                        state_d[k] = IDLE;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] >= DB_LAST) begin
                        state_d[k] = PRESSED;
                        cnt_d[k]   = '0;
                        rpt_d[k]   = 1'b0;
                        pulse_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = sat_inc(cnt_q[k]);
                    end
                end
                PRESSED: begin
                    if (sync_q[k]) begin
                        state_d[k] = REL_DB;
                        cnt_d[k]   = CNT_ONE;
                    end else if (RPT_MASK[k]) begin
                        // First interval is the hold delay, later ones the repeat period.
                        if (cnt_q[k] >= (rpt_q[k] ? RPT_LAST : HOLD_LAST)) begin
                            cnt_d[k]   = '0;
                            rpt_d[k]   = 1'b1;
                            pulse_d[k] = 1'b1;
                        end else begin
                            cnt_d[k] = sat_inc(cnt_q[k]);
                        end
                    end
                end
                REL_DB: begin
                    if (!sync_q[k]) begin
                        // Release bounce: back to held, hold timing restarts.
                        state_d[k] = PRESSED;
                        cnt_d[k]   = '0;
                        rpt_d[k]   = 1'b0;
                    end else if (cnt_q[k] >= DB_LAST) begin
                        state_d[k] = IDLE;
                        cnt_d[k]   = '0;
                    end else begin
                        cnt_d[k] = sat_inc(cnt_q[k]);
                    end
                end
            endcase
        end
    end

    // Outputs: level follows the debounced state, pulse comes from its flop.
    always_comb begin
        key_level = '0;
        for (int k = 0; k < KEY_W; k++) begin
            key_level[k] = (state_q[k] == PRESSED) || (state_q[k] == REL_DB);
        end
        key_pulse = pulse_q;
    end

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: directed scenarios plus randomized key activity for
// key_filter, every cycle compared with a run-length reference model.
module tb_key_filter;

    localparam int         KEY_W = 4;
    localparam int         DB    = 4;
    localparam int         HOLD  = 20;
    localparam int         RPT   = 8;
    localparam logic [3:0] MASK  = 4'b0011;

    logic             clk  = 1'b0;
    logic             rstn = 1'b0;
    logic [KEY_W-1:0] key_in = '1;
    logic [KEY_W-1:0] key_pulse;
    logic [KEY_W-1:0] key_level;

    always #5 clk = ~clk;

    key_filter #(
        .KEY_W      (KEY_W),
        .DB_CYCLES  (DB),
        .HOLD_CYCLES(HOLD),
        .RPT_CYCLES (RPT),
        .RPT_MASK   (MASK)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .key_in   (key_in),
        .key_pulse(key_pulse),
        .key_level(key_level)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int base    = 0;
    int pulses[$];   // observed pulses, encoded key*10000 + edge relative to base
    int exp_q[$];    // expected pulses, same encoding

    // Reference model: two-sample delay line, then run lengths of the
    // opposite value and time held since the last press / bounce re-entry.
    logic [KEY_W-1:0] m_s1, m_s2, m_lvl, m_pulse;
    int               m_run[KEY_W];
    int               m_age[KEY_W];

    int   left[KEY_W];
    logic pat[9];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    endtask

    task automatic model_edge();
        if (!rstn) begin
            m_s1    = '1;
            m_s2    = '1;
            m_lvl   = '0;
            m_pulse = '0;
            for (int k = 0; k < KEY_W; k++) begin
                m_run[k] = 0;
                m_age[k] = 0;
            end
            return;
        end
        for (int k = 0; k < KEY_W; k++) begin
            m_pulse[k] = 1'b0;
            if (!m_lvl[k]) begin
                if (!m_s2[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_lvl[k]   = 1'b1;
                        m_run[k]   = 0;
                        m_age[k]   = 0;
                        m_pulse[k] = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end else begin
                if (m_s2[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_lvl[k] = 1'b0;
                        m_run[k] = 0;
                    end
                end else if (m_run[k] > 0) begin
                    m_run[k] = 0;
                    m_age[k] = 0;
                end else if (MASK[k]) begin
                    m_age[k]++;
                    if (m_age[k] == HOLD || (m_age[k] > HOLD && (m_age[k] - HOLD) % RPT == 0))
                        m_pulse[k] = 1'b1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = key_in;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("pulse_vs_model", key_pulse, m_pulse);
        check("level_vs_model", key_level, m_lvl);
        for (int k = 0; k < KEY_W; k++)
            if (key_pulse[k] === 1'b1) pulses.push_back(k * 10000 + (cyc - base));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_scenario();
        pulses.delete();
        base = cyc;
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_count"}, pulses.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_edge"}, (i < pulses.size()) ? pulses[i] : -1, exp_q[i]);
    endtask

    initial begin
        // Reset state
        rstn   = 1'b0;
        key_in = '1;
        run(2);
        check("reset_pulse", key_pulse, 4'b0000);
        check("reset_level", key_level, 4'b0000);
        rstn = 1'b1;
        run(5);

        // Clean press of key 2, held 40 cycles, then released
        start_scenario();
        key_in[2] = 1'b0;
        run(40);
        key_in[2] = 1'b1;
        run(5);
        check("s1_level_held", key_level[2], 1);
        run(1);
        check("s1_level_fall", key_level[2], 0);
        run(10);
        exp_q = {20006};
        check_pulses("s1_pulses");

        // Bounce on key 0 before a stable run
        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        start_scenario();
        for (int i = 0; i < 9; i++) begin
            key_in[0] = pat[i];
            step();
        end
        run(11);
        key_in[0] = 1'b1;
        run(10);
        exp_q = {11};
        check_pulses("s2_pulses");

        // Key 1 held 60 cycles: press plus auto-repeat
        start_scenario();
        key_in[1] = 1'b0;
        run(60);
        key_in[1] = 1'b1;
        run(10);
        exp_q = {10006, 10026, 10034, 10042, 10050, 10058};
        check_pulses("s3_pulses");

        // Key 1 release bounce of 2 cycles at cycle 30, then held again
        start_scenario();
        key_in[1] = 1'b0;
        run(29);
        key_in[1] = 1'b1;
        run(2);
        key_in[1] = 1'b0;
        run(27);
        key_in[1] = 1'b1;
        run(10);
        exp_q = {10006, 10026, 10054};
        check_pulses("s4_pulses");

        // Keys 0 and 3 pressed together
        start_scenario();
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        run(6);
        check("s5_pulse_both", key_pulse, 4'b1001);
        check("s5_level_both", key_level, 4'b1001);
        run(4);
        key_in = '1;
        run(10);

        // Reset during key 2 press debounce, key kept held
        start_scenario();
        key_in[2] = 1'b0;
        run(5);
        rstn = 1'b0;
        run(1);
        check("s6_reset_pulse", key_pulse, 4'b0000);
        check("s6_reset_level", key_level, 4'b0000);
        rstn = 1'b1;
        run(8);
        key_in[2] = 1'b1;
        run(10);
        exp_q = {20012};
        check_pulses("s6_pulses");

        // Randomized activity: short glitches, long holds, rare resets
        for (int k = 0; k < KEY_W; k++) left[k] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < KEY_W; k++) begin
                if (left[k] == 0) begin
                    key_in[k] = 1'($urandom_range(0, 1));
                    left[k]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                            : int'($urandom_range(1, 6));
                end
                left[k]--;
            end
            rstn = ($urandom_range(0, 399) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_filter.md
Name: key_filter

Overview:
- Per-key debounce and one-shot stage sitting directly upstream of the vending-machine display/FSM block.
- Converts raw active-low push-button inputs into clean active-high single-cycle press pulses (that block's `key` bus) plus stable debounced levels.
- Optional auto-repeat per key, so a held coin key keeps adding money at a fixed rate.
- Keys are filtered independently; no key affects another.

Parameters:
- KEY_W, 4, number of keys.
- DB_CYCLES, 1_000_000, consecutive stable samples required to accept a press or release (20 ms at 50 MHz).
- HOLD_CYCLES, 50_000_000, cycles a key must remain in PRESSED before the first repeat pulse (1 s).
- RPT_CYCLES, 10_000_000, cycles between subsequent repeat pulses (200 ms).
- RPT_MASK, 4'b0011, bit i = 1 enables auto-repeat for key i.

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, synchronous active-low reset.
- key_in, input, KEY_W, raw button inputs, active-low (0 = pressed), asynchronous to clk.
- key_pulse, output, KEY_W, one-clock active-high pulse per accepted press or repeat.
- key_level, output, KEY_W, debounced state, 1 = pressed.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rstn).
- Synchroniser:
  - 2-FF synchroniser per bit on key_in; both FFs reset to 1 (released).
  - FSM acts on the second FF output ("sync").
- Reset values, applied at a clk edge with rstn=0:
  - key_pulse=0, key_level=0.
  - All FSMs in IDLE; all counters 0.
- Per-key FSM states:
  - IDLE: key_level=0, counter=0.
    - sync=0 → PRESS_DB with counter=1.
  - PRESS_DB:
    - sync=0 → counter+1.
    - sync=1 → IDLE, counter=0, no pulse.
    - When counter reaches DB_CYCLES while sync=0 → PRESSED, key_level=1, key_pulse[i]=1 for exactly one cycle, counter=0.
  - PRESSED:
    - sync=1 → REL_DB with counter=1.
    - Otherwise, if RPT_MASK[i]=1, the hold counter increments. At HOLD_CYCLES it emits one pulse and reloads so later pulses occur every RPT_CYCLES.
    - If RPT_MASK[i]=0, no further pulses.
  - REL_DB: key_level stays 1, no pulses.
    - sync=1 → counter+1; on reaching DB_CYCLES → IDLE, key_level=0.
    - sync=0 (release bounce) → PRESSED, hold/repeat counter restarts from 0, no pulse.
- Latency: key_in first sampled low at edge 1 and held → key_pulse high in the cycle after edge DB_CYCLES+2, for one cycle. Release latency is identical for key_level falling.
- Pulse width: key_pulse[i] is never high for two consecutive cycles.
  - Repeat pulses are spaced exactly RPT_CYCLES apart.
  - First repeat is HOLD_CYCLES cycles after the press pulse.
- Simultaneous keys: processed independently. key_pulse may have several bits set in one cycle; the consumer resolves priority.
- Reset mid-operation: everything returns to the reset state and no pulse is emitted.
  - A key still held when rstn deasserts is debounced afresh and then produces exactly one press pulse.
- Counters: width $clog2(max(DB_CYCLES, HOLD_CYCLES, RPT_CYCLES)+1), unsigned, saturating (never wrap).
  - Hold counter stops once repeating is disabled or the key leaves PRESSED.
- Glitch shorter than DB_CYCLES samples: ignored in both directions.

Test Plan (sim overrides: DB_CYCLES=4, HOLD_CYCLES=20, RPT_CYCLES=8, RPT_MASK=4'b0011):
- Clean press of key_in[2] held 40 cycles, then release → one key_pulse[2] at edge 6, key_level[2] high from edge 6 until 6 cycles after release, no repeats.
- key_in[0] bounce pattern 0,1,0,0,1,0,0,0,0 held → single pulse only after the 4-sample stable run; no pulse on the early partial runs.
- key_in[1] held 60 cycles → press pulse at edge 6, repeat pulses at edges 26, 34, 42, 50, 58.
- key_in[1] release with 2-cycle bounce back low at cycle 30, then held → no pulse on the bounce; first repeat 20 cycles after re-entry into PRESSED.
- key_in[0] and key_in[3] pressed on the same edge → key_pulse=4'b1001 in one cycle; levels both 1.
- rstn=0 for 1 cycle during PRESS_DB of key 2 (counter=3), key still held → outputs 0 at reset, then a single pulse 6 cycles after rstn returns high.
